// File: rtl/top_write_back.sv
`default_nettype none
// ============================================================================
// Module      : top_write_back
// Description : Write-back stage of the pipelined MIPS. It holds the MEM/WB
//               pipeline register, aligns and sign/zero-extends load data,
//               and selects the ALU or memory result for the register-file
//               write port. It also tracks program termination (HALT) and
//               counts executed cycles for the debug unit.
//               Optional cycle counter: define WB_CONTADOR_CICLOS_EN to
//               build it. When the macro is undefined, o_contador_ciclos
//               is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module top_write_back #(
    parameter int CANT_REGISTROS                  = 32,
    parameter int CANT_BITS_REGISTROS             = 32,
    parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
    parameter int CANT_BITS_CONTADOR              = 32
) (
    input  logic                                       i_clock,
    input  logic                                       i_soft_reset,
    input  logic                                       i_enable_pipeline,
    input  logic                                       i_RegWrite,
    input  logic                                       i_MemtoReg,
    input  logic [$clog2(CANT_REGISTROS)-1:0]          i_registro_destino,
    input  logic                                       i_halt_detected,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_data_alu,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_data_mem,
    input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos,
    output logic                                       o_RegWrite,
    output logic [$clog2(CANT_REGISTROS)-1:0]          o_registro_destino,
    output logic [CANT_BITS_REGISTROS-1:0]             o_data_write_reg,
    output logic                                       o_halt_detected,
    output logic [CANT_BITS_CONTADOR-1:0]              o_contador_ciclos,
    output logic                                       o_soft_reset_ack
);

    localparam int c_BITS_DESTINO = $clog2(CANT_REGISTROS);

    // Load-type encodings; anything not listed behaves as a full-word load.
    localparam logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] c_SEL_LW  = 'd0;
    localparam logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] c_SEL_LB  = 'd1;
    localparam logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] c_SEL_LH  = 'd2;
    localparam logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] c_SEL_LBU = 'd3;
    localparam logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] c_SEL_LHU = 'd4;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // MEM/WB pipeline register fields
    logic                                       r_regwrite;
    logic                                       r_memtoreg;
    logic [c_BITS_DESTINO-1:0]                  r_registro_destino;
    logic                                       r_halt;
    logic [CANT_BITS_REGISTROS-1:0]             r_data_alu;
    logic [CANT_BITS_REGISTROS-1:0]             r_data_mem;
    logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] r_select;
    logic                                       r_soft_reset_ack;

    logic                           w_run;
    logic                           w_latch_en;
    logic [1:0]                     w_offset;
    logic [7:0]                     w_byte;
    logic [15:0]                    w_half;
    logic [CANT_BITS_REGISTROS-1:0] w_mem_aligned;

    assign w_run      = (r_state == ST_RUN);
    assign w_latch_en = i_enable_pipeline && w_run;

    // FSM state register; reset always forces RUN, even when a halt is pending
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a latched HALT entry moves to HALTED, which holds until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:    if (r_halt) w_state_next = ST_HALTED;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // MEM/WB latch; advances only while running and the pipeline is enabled
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            r_regwrite         <= 1'b0;
            r_memtoreg         <= 1'b0;
            r_registro_destino <= '0;
            r_halt             <= 1'b0;
            r_data_alu         <= '0;
            r_data_mem         <= '0;
            r_select           <= '0;
        end else if (w_latch_en) begin
            r_regwrite         <= i_RegWrite;
            r_memtoreg         <= i_MemtoReg;
            r_registro_destino <= i_registro_destino;
            r_halt             <= i_halt_detected;
            r_data_alu         <= i_data_alu;
            r_data_mem         <= i_data_mem;
            r_select           <= i_select_bytes_mem_datos;
        end
    end

    // Reset acknowledge: one-cycle echo of every sampled reset
    always_ff @(posedge i_clock) begin
        r_soft_reset_ack <= i_soft_reset;
    end

    assign w_offset = r_data_alu[1:0];

    // Byte/halfword extraction from the little-endian word
    always_comb begin
        w_byte = r_data_mem[7:0];
        case (w_offset)
            2'd0:    w_byte = r_data_mem[7:0];
            2'd1:    w_byte = r_data_mem[15:8];
            2'd2:    w_byte = r_data_mem[23:16];
            2'd3:    w_byte = r_data_mem[31:24];
            default: w_byte = r_data_mem[7:0];
        endcase
        w_half = w_offset[1] ? r_data_mem[31:16] : r_data_mem[15:0];
    end

    // Load extension by load type; unknown selectors fall back to a full word
    always_comb begin
        w_mem_aligned = r_data_mem;
        case (r_select)
            c_SEL_LW:  w_mem_aligned = r_data_mem;
            c_SEL_LB:  w_mem_aligned = {{(CANT_BITS_REGISTROS-8){w_byte[7]}}, w_byte};
            c_SEL_LH:  w_mem_aligned = {{(CANT_BITS_REGISTROS-16){w_half[15]}}, w_half};
            c_SEL_LBU: w_mem_aligned = {{(CANT_BITS_REGISTROS-8){1'b0}}, w_byte};
            c_SEL_LHU: w_mem_aligned = {{(CANT_BITS_REGISTROS-16){1'b0}}, w_half};
            default:   w_mem_aligned = r_data_mem;
        endcase
    end

    // The HALT entry itself never writes, and $0 is never written
    assign o_RegWrite         = r_regwrite && (r_registro_destino != '0) && w_run && !r_halt;
    assign o_registro_destino = r_registro_destino;
    assign o_data_write_reg   = r_memtoreg ? w_mem_aligned : r_data_alu;
    assign o_halt_detected    = (r_state == ST_HALTED);
    assign o_soft_reset_ack   = r_soft_reset_ack;

`ifdef WB_CONTADOR_CICLOS_EN
    logic [CANT_BITS_CONTADOR-1:0] r_contador;

    // Executed-cycle counter; saturates instead of wrapping, frozen once halted
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            r_contador <= '0;
        end else if (i_enable_pipeline && w_run && (r_contador != '1)) begin
            r_contador <= r_contador + 1'b1;
        end
    end

    assign o_contador_ciclos = r_contador;
`else
    assign o_contador_ciclos = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_top_write_back.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_write_back
// Description : Directed self-checking bench for top_write_back. Expected
//               counter values follow WB_CONTADOR_CICLOS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_write_back;

    localparam int CNT_W = 8;
`ifdef WB_CONTADOR_CICLOS_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        regw;
    logic        m2r;
    logic [4:0]  dest;
    logic        halt;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  sel;

    logic             o_regw;
    logic [4:0]       o_dest;
    logic [31:0]      o_data;
    logic             o_halt;
    logic [CNT_W-1:0] o_cnt;
    logic             o_ack;

    int n_cmp = 0;
    int n_err = 0;

    top_write_back #(
        .CANT_REGISTROS                  (32),
        .CANT_BITS_REGISTROS             (32),
        .CANT_BITS_SELECT_BYTES_MEM_DATA (3),
        .CANT_BITS_CONTADOR              (CNT_W)
    ) dut (
        .i_clock                  (clk),
        .i_soft_reset             (rst),
        .i_enable_pipeline        (en),
        .i_RegWrite               (regw),
        .i_MemtoReg               (m2r),
        .i_registro_destino       (dest),
        .i_halt_detected          (halt),
        .i_data_alu               (alu),
        .i_data_mem               (mem),
        .i_select_bytes_mem_datos (sel),
        .o_RegWrite               (o_regw),
        .o_registro_destino       (o_dest),
        .o_data_write_reg         (o_data),
        .o_halt_detected          (o_halt),
        .o_contador_ciclos        (o_cnt),
        .o_soft_reset_ack         (o_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
        return CNT_ON ? CNT_W'(v) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; halt = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // reset with a halt request pending: reset must win
        rst = 1'b1; en = 1'b1; regw = 1'b1; m2r = 1'b1; dest = 5'd9; halt = 1'b1;
        alu = 32'h1234; mem = 32'h5678; sel = 3'd0;
        tick(); tick();
        n_cmp++; if (o_ack !== 1'b1) begin n_err++; $display("FAIL reset_ack_high got=%b exp=1", o_ack); end
        n_cmp++; if (o_regw !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got=%b exp=0", o_regw); end
        n_cmp++; if (o_dest !== 5'd0) begin n_err++; $display("FAIL reset_dest got=%0d exp=0", o_dest); end
        n_cmp++; if (o_data !== 32'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", o_data); end
        n_cmp++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL reset_halt got=%b exp=0", o_halt); end
        n_cmp++; if (o_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", o_cnt); end
        rst = 1'b0; halt = 1'b0; en = 1'b0;
        tick();
        n_cmp++; if (o_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack_low got=%b exp=0", o_ack); end
        n_cmp++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL reset_halt_wins got=%b exp=0", o_halt); end
    endtask

    task automatic test_load_word();
        en = 1'b1; regw = 1'b1; m2r = 1'b1; dest = 5'd5; halt = 1'b0;
        alu = 32'd0; mem = 32'hFFDECBAA; sel = 3'd0;
        tick();
        n_cmp++; if (o_regw !== 1'b1) begin n_err++; $display("FAIL lw_regwrite got=%b exp=1", o_regw); end
        n_cmp++; if (o_dest !== 5'd5) begin n_err++; $display("FAIL lw_dest got=%0d exp=5", o_dest); end
        n_cmp++; if (o_data !== 32'hFFDECBAA) begin n_err++; $display("FAIL lw_data got=%h exp=ffdecbaa", o_data); end
        n_cmp++; if (o_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL lw_cnt got=%0d exp=%0d", o_cnt, exp_cnt(1)); end
    endtask

    task automatic test_extension();
        logic [2:0]  t_sel [7];
        logic [31:0] t_alu [7];
        logic [31:0] t_exp [7];
        t_sel[0] = 3'd1; t_alu[0] = 32'd9;  t_exp[0] = 32'hFFFFFFCB;  // LB  offset 1
        t_sel[1] = 3'd3; t_alu[1] = 32'd9;  t_exp[1] = 32'h000000CB;  // LBU offset 1
        t_sel[2] = 3'd2; t_alu[2] = 32'd10; t_exp[2] = 32'hFFFFFFDE;  // LH  upper half
        t_sel[3] = 3'd4; t_alu[3] = 32'd8;  t_exp[3] = 32'h0000CBAA;  // LHU lower half
        t_sel[4] = 3'd6; t_alu[4] = 32'd9;  t_exp[4] = 32'hFFDECBAA;  // unknown -> LW
        t_sel[5] = 3'd1; t_alu[5] = 32'd0;  t_exp[5] = 32'hFFFFFFAA;  // LB  offset 0
        t_sel[6] = 3'd3; t_alu[6] = 32'd11; t_exp[6] = 32'h000000FF;  // LBU offset 3
        en = 1'b1; regw = 1'b1; m2r = 1'b1; dest = 5'd2; mem = 32'hFFDECBAA;
        for (int i = 0; i < 7; i++) begin
            sel = t_sel[i]; alu = t_alu[i];
            tick();
            n_cmp++;
            if (o_data !== t_exp[i]) begin
                n_err++;
                $display("FAIL ext_%0d sel=%0d addr=%0d got=%h exp=%h", i, t_sel[i], t_alu[i], o_data, t_exp[i]);
            end
        end
    endtask

    task automatic test_alu_zero();
        en = 1'b1; regw = 1'b1; m2r = 1'b0; dest = 5'd3; alu = 32'd8; sel = 3'd0;
        tick();
        n_cmp++; if (o_data !== 32'd8) begin n_err++; $display("FAIL alu_data got=%h exp=8", o_data); end
        n_cmp++; if (o_regw !== 1'b1) begin n_err++; $display("FAIL alu_regwrite got=%b exp=1", o_regw); end
        dest = 5'd0;
        tick();
        n_cmp++; if (o_regw !== 1'b0) begin n_err++; $display("FAIL zero_reg_suppress got=%b exp=0", o_regw); end
    endtask

    task automatic test_stall();
        apply_reset();
        en = 1'b1; regw = 1'b1; m2r = 1'b0; dest = 5'd6; alu = 32'h11; sel = 3'd0;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dest = 5'(10 + i); alu = 32'hA0 + 32'(i); m2r = i[0];
            tick();
            n_cmp++;
            if (o_data !== 32'h11 || o_dest !== 5'd6 || o_regw !== 1'b1 || o_cnt !== exp_cnt(1)) begin
                n_err++;
                $display("FAIL stall_hold_%0d got data=%h dest=%0d we=%b cnt=%0d exp data=11 dest=6 we=1 cnt=%0d",
                         i, o_data, o_dest, o_regw, o_cnt, exp_cnt(1));
            end
        end
        en = 1'b1; m2r = 1'b0; dest = 5'd14; alu = 32'hA4;
        tick();
        n_cmp++;
        if (o_data !== 32'hA4 || o_dest !== 5'd14 || o_cnt !== exp_cnt(2)) begin
            n_err++;
            $display("FAIL stall_resume got data=%h dest=%0d cnt=%0d exp data=a4 dest=14 cnt=%0d",
                     o_data, o_dest, o_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_counter();
        apply_reset();
        en = 1'b1; regw = 1'b0;
        repeat (10) tick();
        n_cmp++; if (o_cnt !== exp_cnt(10)) begin n_err++; $display("FAIL cnt_10 got=%0d exp=%0d", o_cnt, exp_cnt(10)); end
    endtask

    task automatic test_saturation();
        apply_reset();
        en = 1'b1; regw = 1'b0;
        repeat (300) tick();
        n_cmp++; if (o_cnt !== exp_cnt(255)) begin n_err++; $display("FAIL cnt_saturate got=%0d exp=%0d", o_cnt, exp_cnt(255)); end
    endtask

    task automatic test_halt();
        apply_reset();
        en = 1'b1; regw = 1'b1; m2r = 1'b0; dest = 5'd7; halt = 1'b1; alu = 32'h77; sel = 3'd0;
        tick();
        n_cmp++; if (o_regw !== 1'b0) begin n_err++; $display("FAIL halt_entry_no_write got=%b exp=0", o_regw); end
        tick();
        n_cmp++; if (o_halt !== 1'b1) begin n_err++; $display("FAIL halt_detected got=%b exp=1", o_halt); end
        n_cmp++; if (o_cnt !== exp_cnt(2)) begin n_err++; $display("FAIL halt_cnt got=%0d exp=%0d", o_cnt, exp_cnt(2)); end
        halt = 1'b0; dest = 5'd8; alu = 32'h88;
        repeat (5) tick();
        n_cmp++;
        if (o_halt !== 1'b1 || o_regw !== 1'b0 || o_dest !== 5'd7 || o_cnt !== exp_cnt(2)) begin
            n_err++;
            $display("FAIL halt_frozen got halt=%b we=%b dest=%0d cnt=%0d exp halt=1 we=0 dest=7 cnt=%0d",
                     o_halt, o_regw, o_dest, o_cnt, exp_cnt(2));
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (o_ack !== 1'b1 || o_halt !== 1'b0 || o_regw !== 1'b0 || o_dest !== 5'd0 || o_data !== 32'd0 || o_cnt !== '0) begin
            n_err++;
            $display("FAIL halt_reset got ack=%b halt=%b we=%b dest=%0d data=%h cnt=%0d exp ack=1 others=0",
                     o_ack, o_halt, o_regw, o_dest, o_data, o_cnt);
        end
        rst = 1'b0; regw = 1'b1; dest = 5'd4; alu = 32'h44; m2r = 1'b0;
        tick();
        n_cmp++;
        if (o_regw !== 1'b1 || o_data !== 32'h44 || o_ack !== 1'b0) begin
            n_err++;
            $display("FAIL halt_rerun got we=%b data=%h ack=%b exp we=1 data=44 ack=0", o_regw, o_data, o_ack);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; regw = 1'b0; m2r = 1'b0; dest = '0; halt = 1'b0;
        alu = '0; mem = '0; sel = '0;
        test_reset();
        test_load_word();
        test_extension();
        test_alu_zero();
        test_stall();
        test_counter();
        test_saturation();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
